// File: rtl/instruction_fetch.sv
// Program counter and instruction-fetch stage: drives a one-cycle-latency ROM
// and registers the returned word, its address and a valid flag for the splitter.
module instruction_fetch #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned INSTR_W  = 14,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               halt,
   input  logic               stall,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_addr,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_en,
   input  logic [INSTR_W-1:0] mem_data,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   output logic               running
);

   typedef enum logic {
      ST_HALT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [ADDR_W-1:0]    fa_q, fa_d;
   logic                 fv_q, fv_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
   logic                 instr_valid_q, instr_valid_d;
   logic                 advance_c;

   // Run-control state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_HALT;
      end else begin
         state_q <= state_d;
      end
   end

   // Halt wins over start; start in RUN is a no-op
   always_comb begin
      state_d = state_q;
      if (halt) begin
         state_d = ST_HALT;
      end else if ((state_q == ST_HALT) && start) begin
         state_d = ST_RUN;
      end
   end

   // Fetch enable: any redirect or freeze blocks the ROM so its output holds
   always_comb begin
      advance_c = 1'b0;
      if ((state_q == ST_RUN) && !stall && !jump && !halt) begin
         advance_c = 1'b1;
      end
   end

   // Pipeline next-state: redirect/squash first, then advance, otherwise hold
   always_comb begin
      pc_d          = pc_q;
      fa_d          = fa_q;
      fv_d          = fv_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      if (halt || jump) begin
         fv_d          = 1'b0;
         instr_valid_d = 1'b0;
         if (jump) begin
            pc_d = jump_addr;
         end else if ((state_q == ST_RUN) && fv_q) begin
            pc_d = fa_q;
         end
      end else if (advance_c) begin
         pc_d          = pc_q + ADDR_W'(1);
         fa_d          = pc_q;
         fv_d          = 1'b1;
         instr_d       = mem_data;
         instr_pc_d    = fa_q;
         instr_valid_d = fv_q;
      end else if (state_q == ST_HALT) begin
         instr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= ADDR_W'(RESET_PC);
         fa_q          <= '0;
         fv_q          <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         fa_q          <= fa_d;
         fv_q          <= fv_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign mem_addr    = pc_q;
   assign mem_en      = advance_c;
   assign instruction = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a synchronous ROM model holding ROM[i] = i + 0x100.
module tb_instruction_fetch;

   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned INSTR_W = 14;

   logic               clk = 1'b0;
   logic               rst_n, start, halt, stall, jump;
   logic [ADDR_W-1:0]  jump_addr;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_en;
   logic [INSTR_W-1:0] mem_data;
   logic [INSTR_W-1:0] instruction;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               running;

   int n_checks = 0;
   int n_pass   = 0;

   instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
      .jump(jump), .jump_addr(jump_addr), .mem_addr(mem_addr), .mem_en(mem_en),
      .mem_data(mem_data), .instruction(instruction), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .running(running)
   );

   always #5 clk = ~clk;

   // ROM model: one-cycle latency, output holds while mem_en is low
   initial mem_data = '0;
   always @(posedge clk) if (mem_en) mem_data <= INSTR_W'(mem_addr) + INSTR_W'(14'h100);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; halt = 0; stall = 0; jump = 0; jump_addr = '0;
   endtask

   // Reset, start from RESET_PC and run until instr_pc == target is reported
   task automatic run_to(input logic [ADDR_W-1:0] target);
      bit found = 0;
      idle_inputs();
      rst_n = 0; step(); rst_n = 1;
      start = 1; step(); start = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (instr_valid && instr_pc == target) found = 1;
      end
      n_checks++;
      if (!found) $display("FAIL run_to timeout waiting for pc %h", target);
      else n_pass++;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0; step();
      n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else n_pass++;
      n_checks++; if (instruction !== 14'h0) $display("FAIL reset_instr got %h want 0", instruction); else n_pass++;
      n_checks++; if (instr_pc !== 11'h0) $display("FAIL reset_pc got %h want 0", instr_pc); else n_pass++;
      n_checks++; if ({running, mem_en} !== 2'b00) $display("FAIL reset_run_en got %b want 00", {running, mem_en}); else n_pass++;
      n_checks++; if (mem_addr !== 11'h0) $display("FAIL reset_addr got %h want 0", mem_addr); else n_pass++;
      rst_n = 1;
   endtask

   task automatic test_start_seq();
      start = 1; step(); start = 0;
      n_checks++; if ({running, mem_en, instr_valid} !== 3'b110) $display("FAIL start_S got %b want 110", {running, mem_en, instr_valid}); else n_pass++;
      step();
      n_checks++; if (instr_valid !== 1'b0) $display("FAIL start_S1_valid got %b want 0", instr_valid); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 11'(i) || instruction !== 14'(14'h100 + i))
            $display("FAIL seq_%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                     i, instr_valid, instr_pc, instruction, 11'(i), 14'(14'h100 + i));
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      step(); step();
      n_checks++; if (instr_pc !== 11'h5) $display("FAIL stall_pre got %h want 5", instr_pc); else n_pass++;
      stall = 1; #1;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (mem_en !== 1'b0) $display("FAIL stall_en_%0d got %b want 0", k, mem_en); else n_pass++;
         step();
         n_checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 11'h5 || instruction !== 14'h105)
            $display("FAIL stall_hold_%0d got v=%b pc=%h ins=%h want v=1 pc=005 ins=0105", k, instr_valid, instr_pc, instruction);
         else n_pass++;
      end
      stall = 0;
      for (int i = 6; i < 9; i++) begin
         step();
         n_checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 11'(i) || instruction !== 14'(14'h100 + i))
            $display("FAIL post_stall_%0d got v=%b pc=%h ins=%h want v=1 pc=%h", i, instr_valid, instr_pc, instruction, 11'(i));
         else n_pass++;
      end
   endtask

   task automatic test_jump();
      logic [ADDR_W-1:0] exp_pc [4];
      run_to(11'h2);
      jump = 1; jump_addr = 11'h3F0; step(); jump = 0;
      n_checks++; if (instr_valid !== 1'b0 || instr_pc !== 11'h2) $display("FAIL jump_J got v=%b pc=%h want v=0 pc=002", instr_valid, instr_pc); else n_pass++;
      n_checks++; if (mem_addr !== 11'h3F0) $display("FAIL jump_addr got %h want 3f0", mem_addr); else n_pass++;
      step();
      n_checks++; if (instr_valid !== 1'b0) $display("FAIL jump_J1 got %b want 0", instr_valid); else n_pass++;
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 11'h3F0 || instruction !== 14'h4F0) $display("FAIL jump_tgt got v=%b pc=%h ins=%h want v=1 pc=3f0 ins=04f0", instr_valid, instr_pc, instruction); else n_pass++;
      step();
      n_checks++; if (instr_pc !== 11'h3F1 || instruction !== 14'h4F1) $display("FAIL jump_tgt1 got pc=%h ins=%h want 3f1 04f1", instr_pc, instruction); else n_pass++;
      // wrap through the top of the address space
      jump = 1; jump_addr = 11'h7FE; step(); jump = 0;
      step();
      exp_pc[0] = 11'h7FE; exp_pc[1] = 11'h7FF; exp_pc[2] = 11'h000; exp_pc[3] = 11'h001;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instruction !== 14'(exp_pc[i]) + 14'h100)
            $display("FAIL wrap_%0d got v=%b pc=%h ins=%h want pc=%h", i, instr_valid, instr_pc, instruction, exp_pc[i]);
         else n_pass++;
      end
   endtask

   task automatic test_halt();
      run_to(11'h8);
      halt = 1; step(); halt = 0;
      n_checks++; if ({running, instr_valid, mem_en} !== 3'b000) $display("FAIL halt_flags got %b want 000", {running, instr_valid, mem_en}); else n_pass++;
      n_checks++; if (mem_addr !== 11'h9) $display("FAIL halt_rewind got %h want 009", mem_addr); else n_pass++;
      start = 1; step(); start = 0;
      step();
      n_checks++; if (instr_valid !== 1'b0) $display("FAIL halt_restart_bubble got %b want 0", instr_valid); else n_pass++;
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 11'h9 || instruction !== 14'h109) $display("FAIL halt_resume got v=%b pc=%h ins=%h want v=1 pc=009 ins=0109", instr_valid, instr_pc, instruction); else n_pass++;
   endtask

   task automatic test_simultaneous();
      run_to(11'h4);
      stall = 1; jump = 1; jump_addr = 11'h123; step(); stall = 0; jump = 0;
      n_checks++; if (mem_addr !== 11'h123 || instr_valid !== 1'b0) $display("FAIL jump_stall got addr=%h v=%b want 123 0", mem_addr, instr_valid); else n_pass++;
      step(); step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 11'h123 || instruction !== 14'h223) $display("FAIL jump_stall_tgt got v=%b pc=%h ins=%h want v=1 pc=123 ins=0223", instr_valid, instr_pc, instruction); else n_pass++;
      halt = 1; jump = 1; jump_addr = 11'h055; step(); halt = 0; jump = 0;
      n_checks++; if ({running, instr_valid} !== 2'b00 || mem_addr !== 11'h055) $display("FAIL halt_jump got run/v=%b addr=%h want 00 055", {running, instr_valid}, mem_addr); else n_pass++;
      jump = 1; jump_addr = 11'h200; step(); jump = 0;
      n_checks++; if (running !== 1'b0 || mem_addr !== 11'h200) $display("FAIL halt_state_jump got run=%b addr=%h want 0 200", running, mem_addr); else n_pass++;
      start = 1; step(); start = 0; step(); step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 11'h200 || instruction !== 14'h300) $display("FAIL entry_point got v=%b pc=%h ins=%h want v=1 pc=200 ins=0300", instr_valid, instr_pc, instruction); else n_pass++;
      rst_n = 0; start = 1; jump = 1; jump_addr = 11'h3AA; step();
      idle_inputs(); rst_n = 1;
      n_checks++;
      if ({running, mem_en, instr_valid} !== 3'b000 || instr_pc !== 11'h0 || instruction !== 14'h0 || mem_addr !== 11'h0)
         $display("FAIL mid_reset got run/en/v=%b pc=%h ins=%h addr=%h want 000 0 0 0", {running, mem_en, instr_valid}, instr_pc, instruction, mem_addr);
      else n_pass++;
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      step();
      test_reset();
      test_start_seq();
      test_stall();
      test_jump();
      test_halt();
      test_simultaneous();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Program-counter and instruction-fetch stage sitting directly upstream of the instruction splitter.
- Holds the 11-bit PC and drives a synchronous instruction ROM (one-cycle read latency, output held while its enable is low).
- Registers the returned 14-bit word as `instruction` with a valid flag and its address; the splitter consumes `instruction`.
- Handles sequential fetch, jumps from the decoder, stalls, and a start/halt run control.

## Interface

Parameters:
- ADDR_W, 11, PC / ROM address width (equals the splitter's D field width)
- INSTR_W, 14, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  reset, synchronous and active-low
- start  input  1  leave HALT, begin/resume fetching
- halt  input  1  stop fetching, squash in-flight work
- stall  input  1  freeze pipeline (downstream not ready)
- jump  input  1  redirect PC to jump_addr
- jump_addr  input  ADDR_W  jump target
- mem_addr  output  ADDR_W  ROM address; combinational copy of pc
- mem_en  output  1  ROM read/clock enable
- mem_data  input  INSTR_W  ROM data for the address presented at the previous enabled edge
- instruction  output  INSTR_W  registered fetched word
- instr_pc  output  ADDR_W  address of `instruction`
- instr_valid  output  1  `instruction` is valid this cycle
- running  output  1  FSM is in RUN

## Operation

- Internal registers:
  - pc: next address to issue
  - fa/fv: address and valid of the fetch in flight
  - state: HALT or RUN
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, fa=0, fv=0, state=HALT
  - instruction=0, instr_pc=0, instr_valid=0
  - Resulting outputs: mem_en=0, running=0
- mem_en = (state==RUN) && !stall && !jump && !halt.
- advance = mem_en. On an advance edge:
  - pc<=pc+1
  - fa<=pc, fv<=1
  - instruction<=mem_data, instr_pc<=fa, instr_valid<=fv
- PC wraps from 2^ADDR_W-1 to 0 with no flag.
- Stall in RUN (no jump/halt): pc, fa, fv, instruction, instr_pc and instr_valid all hold. The ROM output holds because mem_en=0, so no data is lost.
- Jump (any state, priority over stall):
  - pc<=jump_addr, fv<=0, instr_valid<=0
  - instruction and instr_pc hold their old values
  - state is unchanged, except when halt is also asserted (see below)
- Halt in RUN:
  - state<=HALT, fv<=0, instr_valid<=0
  - pc<=fa if fv=1 (rewind the squashed fetch), else pc holds
- Halt and jump together: pc<=jump_addr, state<=HALT.
- HALT state:
  - No fetching, mem_en=0, instr_valid=0
  - start=1 with halt=0 -> RUN next cycle with pc unchanged
  - jump in HALT loads pc (sets the entry point)
  - halt has priority over start in both states
- start in RUN is ignored.

## Timing

- Fetch latency: address issued at edge N (advance) -> mem_data valid during cycle N+1 -> instruction/instr_valid registered at edge N+1 (with the next advance).
- From start accepted at edge S: state=RUN after S.
  - First advance at S+1 issues pc.
  - instr_valid=1 after edge S+2, instr_pc = starting pc.
  - Sustained throughput thereafter is one instruction per cycle.
- Jump taken at edge J:
  - instr_valid=0 after J and after J+1.
  - Target instruction valid after edge J+2.
  - Penalty is 2 bubble cycles.
- A stall of k cycles delays every subsequent output by exactly k cycles and causes no duplicated or skipped addresses.
- Reset mid-operation takes effect at the next edge regardless of other inputs and wins over all of them.

## Test plan

- Reset then start, no stall, ROM[i]=i+0x100:
  - instr_valid rises two edges after start-accept.
  - instr_pc sequence 0,1,2,3 with instruction 0x100,0x101,0x102,0x103 on consecutive cycles.
- Stall held 3 cycles mid-stream while instr_pc=5:
  - Outputs hold at pc 5 for 3 cycles, then 6,7,… follow with no gap or repeat.
  - mem_en=0 throughout the stall.
- Jump to 0x3F0 while instr_pc=2:
  - Two cycles with instr_valid=0.
  - Then instr_pc 0x3F0,0x3F1; addresses 3 and 4 are never reported valid.
- Wrap: jump to 0x7FE:
  - Reported instr_pc 0x7FE,0x7FF,0x000,0x001.
- Halt in RUN with fv=1, fa=9:
  - Next cycle running=0, instr_valid=0, pc=9.
  - After start, first reported instr_pc is 9.
- Simultaneous cases:
  - jump+stall loads the target and the stall does not block the redirect.
  - halt+jump ends in HALT with pc=jump_addr.
  - rst_n=0 during RUN returns all outputs to reset values on the next edge.
